// File: rtl/imu_sync_fifo.sv
// First-word-fall-through FIFO for 64-bit time-aligned IMU samples.
// Overflow either rejects the incoming sample or evicts the oldest entry.
// Also reports fill level, a saturating overflow count and a sticky underflow flag.
module imu_sync_fifo #(
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AFULL_THRESH = 12,
   parameter bit          DROP_OLDEST  = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         fifo_read_en,
   output logic [DATA_W-1:0]            fifo_data_out,
   output logic                         fifo_empty,
   output logic                         full,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level,
   output logic [15:0]                  overflow_cnt,
   output logic                         underflow_err
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [15:0]     ovf_cnt_q, ovf_cnt_d;
   logic            uflow_q, uflow_d;

   logic is_empty, is_full;
   logic do_pop, do_write, evict, ovf_event, rd_adv;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CntW'(DEPTH));

   // Decode the per-edge action from the request pair and the current occupancy
   always_comb begin
      do_pop    = fifo_read_en & ~is_empty;
      ovf_event = wr_en & is_full & ~fifo_read_en;
      // Drop-oldest turns an overflow into a write plus an implicit pop of the head
      evict     = ovf_event & DROP_OLDEST;
      do_write  = wr_en & (~is_full | do_pop | evict);
      rd_adv    = do_pop | evict;
   end

   // Next-state for pointers, count and status registers
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_cnt_d = ovf_cnt_q;
      uflow_d   = uflow_q;

      if (do_write) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (rd_adv) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_write && !rd_adv) begin
         count_d = count_q + CntW'(1);
      end else if (rd_adv && !do_write) begin
         count_d = count_q - CntW'(1);
      end
      if (ovf_event && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
      if (fifo_read_en && is_empty) begin
         uflow_d = 1'b1;
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_cnt_q <= '0;
         uflow_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_cnt_q <= ovf_cnt_d;
         uflow_q   <= uflow_d;
      end
   end

   // Sample storage; contents are not reset, the pointers make them unreachable
   always_ff @(posedge clk) begin
      if (!rst && do_write) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   assign fifo_data_out = mem[rd_ptr_q];
   assign fifo_empty    = is_empty;
   assign full          = is_full;
   assign almost_full   = (count_q >= CntW'(AFULL_THRESH));
   assign fill_level    = count_q;
   assign overflow_cnt  = ovf_cnt_q;
   assign underflow_err = uflow_q;

endmodule

// File: tb/tb_imu_sync_fifo.sv
// Self-checking bench: two FIFOs (reject-newest and drop-oldest) share stimulus
// and are compared every cycle against queue-based reference models.
module tb_imu_sync_fifo;

   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AFT   = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          fifo_read_en = 1'b0;

   logic [DW-1:0] dout0, dout1;
   logic          empty0, empty1, full0, full1, af0, af1, uf0, uf1;
   logic [4:0]    lvl0, lvl1;
   logic [15:0]   ovf0, ovf1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [DW-1:0] sq [$];
   int            m_ovf [2];
   bit            m_uf  [2];

   always #5 clk = ~clk;

   imu_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .DROP_OLDEST(1'b0)) u_rej (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .fifo_read_en(fifo_read_en),
      .fifo_data_out(dout0), .fifo_empty(empty0), .full(full0), .almost_full(af0),
      .fill_level(lvl0), .overflow_cnt(ovf0), .underflow_err(uf0)
   );

   imu_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .DROP_OLDEST(1'b1)) u_drop (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .fifo_read_en(fifo_read_en),
      .fifo_data_out(dout1), .fifo_empty(empty1), .full(full1), .almost_full(af1),
      .fill_level(lvl1), .overflow_cnt(ovf1), .underflow_err(uf1)
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour on the scratch queue sq for one overflow policy
   task automatic model_edge(input int idx, input bit drop_oldest);
      int sz;
      sz = sq.size();
      if (rst) begin
         sq.delete();
         m_ovf[idx] = 0;
         m_uf[idx]  = 1'b0;
      end else begin
         if (fifo_read_en && sz == 0) m_uf[idx] = 1'b1;
         if (wr_en && fifo_read_en && sz > 0) begin
            void'(sq.pop_front());
            sq.push_back(wr_data);
         end else if (fifo_read_en && sz > 0) begin
            void'(sq.pop_front());
         end else if (wr_en && sz < DEPTH) begin
            sq.push_back(wr_data);
         end else if (wr_en) begin
            if (m_ovf[idx] < 65535) m_ovf[idx]++;
            if (drop_oldest) begin
               void'(sq.pop_front());
               sq.push_back(wr_data);
            end
         end
      end
   endtask

   task automatic check_inst(input string nm, input int idx, input logic [DW-1:0] dout,
                             input logic empty, input logic fl, input logic af,
                             input logic [4:0] lvl, input logic [15:0] ovf, input logic uf);
      int sz;
      sz = sq.size();
      check_eq({nm, ".fifo_empty"},    DW'(empty), DW'(sz == 0));
      check_eq({nm, ".full"},          DW'(fl),    DW'(sz == DEPTH));
      check_eq({nm, ".almost_full"},   DW'(af),    DW'(sz >= AFT));
      check_eq({nm, ".fill_level"},    DW'(lvl),   DW'(sz));
      check_eq({nm, ".overflow_cnt"},  DW'(ovf),   DW'(m_ovf[idx]));
      check_eq({nm, ".underflow_err"}, DW'(uf),    DW'(m_uf[idx]));
      if (sz > 0) check_eq({nm, ".fifo_data_out"}, dout, sq[0]);
   endtask

   // One clock: drive inputs, advance both models at the edge, check 1 time unit later
   task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit p);
      rst = r;
      wr_en = w;
      wr_data = d;
      fifo_read_en = p;
      @(posedge clk);
      sq = q0; model_edge(0, 1'b0); q0 = sq;
      sq = q1; model_edge(1, 1'b1); q1 = sq;
      #1;
      sq = q0; check_inst("rej", 0, dout0, empty0, full0, af0, lvl0, ovf0, uf0);
      sq = q1; check_inst("drop", 1, dout1, empty1, full1, af1, lvl1, ovf1, uf1);
      check_eq("rej.not_full_and_empty",  DW'(full0 & empty0), '0);
      check_eq("drop.not_full_and_empty", DW'(full1 & empty1), '0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0);
   endtask

   task automatic fill_seq(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      int wp, rp;
      do_reset();
      do_reset();

      // Basic FWFT
      step(1'b0, 1'b1, 64'h1111_0000_0000_0001, 1'b0);
      step(1'b0, 1'b1, 64'h1111_0000_0000_0002, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      drain(1);
      check_eq("basic.head_after_pop", dout0, 64'h1111_0000_0000_0002);
      check_eq("basic.level_after_pop", DW'(lvl0), DW'(1));

      // Fill, almost_full, full, drain in order
      do_reset();
      fill_seq(16);
      check_eq("fill.full", DW'(full0), DW'(1));
      drain(16);

      // Overflow under both policies with the same stimulus
      do_reset();
      fill_seq(16);
      step(1'b0, 1'b1, DW'(99), 1'b0);
      check_eq("ovf.rej_head", dout0, DW'(0));
      check_eq("ovf.drop_head", dout1, DW'(1));
      check_eq("ovf.drop_cnt", DW'(ovf1), DW'(1));
      // Full write plus pop is not an overflow
      step(1'b0, 1'b1, DW'(100), 1'b1);
      drain(16);

      // Write plus pop into empty FIFO
      do_reset();
      step(1'b0, 1'b1, DW'(7), 1'b1);
      check_eq("empty_wr_pop.head", dout0, DW'(7));

      // Reset mid-stream with wr_en held high
      do_reset();
      fill_seq(5);
      step(1'b1, 1'b1, DW'(55), 1'b0);
      check_eq("midrst.empty", DW'(empty0), DW'(1));

      // Wraparound with 40 sequential words
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, DW'(1000 + i), i >= 3);
      drain(4);

      // Randomized phases with varying write/read pressure
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin wp = 80; rp = 30; end
            1: begin wp = 30; rp = 80; end
            2: begin wp = 60; rp = 60; end
            default: begin wp = 95; rp = 10; end
         endcase
         for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < wp,
                 {$urandom, $urandom},
                 $urandom_range(0, 99) < rp);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imu_sync_fifo.md
Name: imu_sync_fifo

Overview:
First-word-fall-through FIFO that buffers 64-bit time-aligned IMU samples from the sample packer. It feeds the buffer manager, which reads it through fifo_data_out, fifo_empty and fifo_read_en. On overflow the FIFO either drops the newest sample or discards the oldest to keep the freshest data. It also exposes fill level and sticky/counted error status for the sensor-fusion health monitor.

Parameters:
DATA_W, 64, width of one IMU sample word
DEPTH, 16, number of entries; power of two, minimum 4
AFULL_THRESH, 12, almost_full asserts when count >= this value
DROP_OLDEST, 0, overflow policy: 0 = reject the incoming write, 1 = evict the oldest entry and accept the incoming write

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request from the sample packer
wr_data  in  DATA_W  sample to write
fifo_read_en  in  1  pop request from the buffer manager
fifo_data_out  out  DATA_W  head entry (FWFT); valid whenever fifo_empty=0
fifo_empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_THRESH
fill_level  out  $clog2(DEPTH+1)  current entry count
overflow_cnt  out  16  number of overflow events; saturates at 0xFFFF
underflow_err  out  1  sticky; set by a pop while empty

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values:
  - wr_ptr, rd_ptr and count are 0.
  - fifo_empty=1, full=0, almost_full=0, fill_level=0.
  - overflow_cnt=0, underflow_err=0.
  - Memory contents are not reset.
  - fifo_data_out is don't-care while empty.
- Storage: DEPTH x DATA_W array. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Read path: fifo_data_out = mem[rd_ptr], combinational, so the head is always presented (FWFT).
- Write latency: a write into an empty FIFO raises fifo_data_out/fifo_empty=0 on the cycle after the wr_en edge. There is no same-cycle bypass.
- Pop: when fifo_read_en=1 and count>0, rd_ptr advances at the edge. The next entry appears on the following cycle.
- Per-edge update, with wr = wr_en, rd = fifo_read_en, E = (count==0), F = (count==DEPTH):
  - rd & E: pop ignored; underflow_err<=1. A simultaneous wr is accepted normally (count 0->1).
  - wr & ~F & ~(rd & ~E): write mem[wr_ptr], wr_ptr++, count++.
  - rd & ~E & ~wr: rd_ptr++, count--.
  - wr & rd & ~E (including F): write and pop both occur; count is unchanged. This is not an overflow.
  - wr & F & ~rd, DROP_OLDEST=0: write discarded; pointers and count unchanged; overflow_cnt++.
  - wr & F & ~rd, DROP_OLDEST=1: write mem[wr_ptr], wr_ptr++, rd_ptr++, count stays DEPTH; overflow_cnt++.
- Status timing: full, almost_full, fifo_empty and fill_level are derived from registered count. They update the cycle after the causing edge.
- overflow_cnt saturates at 0xFFFF and does not wrap.
- underflow_err: once set, cleared only by rst.
- Reset mid-operation: all contents are logically flushed. fifo_empty=1 on the cycle after rst is sampled high, regardless of any wr_en or fifo_read_en in that cycle.
- Invariants:
  - count == (wr_ptr - rd_ptr) mod DEPTH, except at count==DEPTH where the pointers are equal.
  - full and fifo_empty are never both 1.

Test Plan:
- Basic FWFT: after reset, write 0x1111_0000_0000_0001 then ...0002 on consecutive cycles, no reads -> fifo_empty=0 one cycle after first write, fifo_data_out=...0001, fill_level=2. Pop once -> fifo_data_out=...0002 next cycle, fill_level=1.
- Fill and almost_full (DEPTH=16, AFULL_THRESH=12): write 16 words 0..15 -> almost_full rises after the 12th write, full=1 after the 16th. Read all -> data 0..15 in order, fifo_empty=1 after the 16th pop.
- Overflow, DROP_OLDEST=0: fill with 0..15, write 99 -> overflow_cnt=1, fill_level=16. Drain yields 0..15; 99 is absent.
- Overflow, DROP_OLDEST=1: fill with 0..15, write 99 -> overflow_cnt=1, fill_level=16, head becomes 1. Drain yields 1..15 then 99.
- Simultaneous operations: when full, wr 100 plus pop in the same cycle -> overflow_cnt unchanged, count=16, data 100 last out. When empty, wr 7 plus pop -> underflow_err=1, fill_level=1, head=7.
- Reset mid-stream: with 5 entries and wr_en held high, assert rst for one cycle -> next cycle fifo_empty=1, fill_level=0, overflow_cnt=0, underflow_err=0. Wraparound then verified by writing and reading 40 sequential words with data matching in order.
